// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared definitions for the RV32 subset instruction encoder.
// Holds the operation codes accepted on op_i, base opcodes, funct3/funct7 values,
// the canonical NOP word and the encoder result record.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_MUL  = 4'd4,
    OP_ADDI = 4'd5,
    OP_LW   = 4'd6,
    OP_SW   = 4'd7,
    OP_BEQ  = 4'd8
  } op_e;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Encoder result: the instruction word plus a flag for rejected field sets.
  typedef struct packed {
    logic [31:0] instr;
    logic        bad;
  } enc_t;

endpackage

// File: rtl/instr_enc_fifo2.sv
// instr_enc_fifo2: 2-entry output buffer of {instr, addr} with valid/ready on both sides.
// Ports: clk/rst (async, active-high), clear (sync flush), in_valid/in_ready/in_instr/in_addr
// on the write side, out_valid/out_ready/out_instr/out_addr (head entry) on the read side.
module instr_enc_fifo2 #(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RST_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr
);

  // Entry 0 is always the head; entry 1 shifts down on pop.
  logic [1:0]        count_q;
  logic [31:0]       instr0_q, instr1_q;
  logic [ADDR_W-1:0] addr0_q, addr1_q;
  logic              push, pop;

  // Ready depends only on occupancy, so a full buffer never takes a push even
  // while it is being popped.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_instr = instr0_q;
  assign out_addr  = addr0_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      instr0_q <= 32'd0;
      instr1_q <= 32'd0;
      addr0_q  <= RST_ADDR;
      addr1_q  <= RST_ADDR;
    end else if (clear) begin
      count_q  <= 2'd0;
      instr0_q <= 32'd0;
      addr0_q  <= RST_ADDR;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            instr0_q <= in_instr;
            addr0_q  <= in_addr;
          end else begin
            instr1_q <= in_instr;
            addr1_q  <= in_addr;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          instr0_q <= instr1_q;
          addr0_q  <= addr1_q;
          count_q  <= count_q - 2'd1;
        end
        // Push and pop together only happens with one entry: replace the head.
        2'b11: begin
          instr0_q <= in_instr;
          addr0_q  <= in_addr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs op/rd/rs1/rs2/imm into RV32 instruction words, tagged with byte addresses.
// Ports: clk_i, rst_i (async high), clear_i; in_valid_i/in_ready_o + op_i/rd_i/rs1_i/rs2_i/imm_i in;
// out_valid_o/out_ready_i + instr_o/addr_o out; err_o sticky illegal flag. Option macro: INSTR_ENC_X0_GUARD_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [3:0]        op_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [11:0]       imm_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              err_o
);

  function automatic enc_t encode(input logic [3:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [11:0] imm);
    enc_t r;
    r.instr = NOP_INSTR;
    r.bad   = 1'b0;
    case (op)
      OP_ADD:  r.instr = {F7_BASE, rs2, rs1, F3_ADD, rd, OPC_RTYPE};
      OP_SUB:  r.instr = {F7_SUB,  rs2, rs1, F3_ADD, rd, OPC_RTYPE};
      OP_AND:  r.instr = {F7_BASE, rs2, rs1, F3_AND, rd, OPC_RTYPE};
      OP_OR:   r.instr = {F7_BASE, rs2, rs1, F3_OR,  rd, OPC_RTYPE};
      OP_MUL:  r.instr = {F7_MUL,  rs2, rs1, F3_ADD, rd, OPC_RTYPE};
      OP_ADDI: r.instr = {imm, rs1, F3_ADD, rd, OPC_IMM};
      OP_LW:   r.instr = {imm, rs1, F3_WORD, rd, OPC_LOAD};
      OP_SW:   r.instr = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OPC_STORE};
      // imm holds the branch offset already shifted right by one.
      OP_BEQ:  r.instr = {imm[11], imm[9:4], rs2, rs1, F3_BEQ, imm[3:0], imm[10], OPC_BRANCH};
      default: begin
        r.instr = NOP_INSTR;
        r.bad   = 1'b1;
      end
    endcase
`ifdef INSTR_ENC_X0_GUARD_EN
    // Writes to x0 are almost certainly a program-builder mistake; flag them.
    if (rd == 5'd0 && (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_ADDI, OP_LW})) begin
      r.instr = NOP_INSTR;
      r.bad   = 1'b1;
    end
`endif
    return r;
  endfunction

  enc_t              enc;
  logic              push;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;

  assign enc  = encode(op_i, rd_i, rs1_i, rs2_i, imm_i);
  // clear_i wins: a push presented in the clear cycle is dropped everywhere.
  assign push = in_valid_i & in_ready_o & ~clear_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
    end else if (clear_i) begin
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
    end else if (push) begin
      addr_q <= addr_q + ADDR_W'(4);
      if (enc.bad) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  instr_enc_fifo2 #(
    .ADDR_W   (ADDR_W),
    .RST_ADDR (BASE_ADDR)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (clear_i),
    .in_valid  (in_valid_i),
    .in_ready  (in_ready_o),
    .in_instr  (enc.instr),
    .in_addr   (addr_q),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i),
    .out_instr (instr_o),
    .out_addr  (addr_o)
  );

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vector table plus hand-written multi-cycle sequences for instr_encoder.
// Ports: none (top-level bench); drives every DUT port and prints one summary line.
// Honours INSTR_ENC_X0_GUARD_EN when choosing the expected result of the rd=0 case.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
  logic [11:0] imm = 12'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] addr;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_i        (op),
    .rd_i        (rd),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .imm_i       (imm),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .instr_o     (instr),
    .addr_o      (addr),
    .err_o       (err)
  );

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Immediate generator view of an encoded word, returned in imm_i form.
  function automatic logic [11:0] imm_of(input logic [3:0] o, input logic [31:0] w);
    case (o)
      4'd5, 4'd6: return w[31:20];
      4'd7:       return {w[31:25], w[11:7]};
      4'd8:       return {w[31], w[7], w[30:25], w[11:8]};
      default:    return 12'd0;
    endcase
  endfunction

  task automatic set_fields(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [11:0] im);
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
  endtask

  task automatic push(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [11:0] im);
    @(negedge clk);
    set_fields(o, d, s1, s2, im);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called at a negedge with one entry queued; pops it and checks the buffer drained.
  task automatic pop_one(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({name, "_drained"}, out_valid, 1'b0);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  logic [31:0] exp_addr;

  initial begin
    vt[0]  = '{4'd5, 5'd1,  5'd0,  5'd0,  12'h00A, 32'h00A00093};
    vt[1]  = '{4'd7, 5'd0,  5'd3,  5'd2,  12'h008, 32'h0021A423};
    vt[2]  = '{4'd8, 5'd0,  5'd1,  5'd2,  12'h004, 32'h00208463};
    vt[3]  = '{4'd6, 5'd5,  5'd6,  5'd0,  12'hFFC, 32'hFFC32283};
    vt[4]  = '{4'd1, 5'd3,  5'd1,  5'd2,  12'h000, 32'h402081B3};
    vt[5]  = '{4'd0, 5'd1,  5'd2,  5'd3,  12'hFFF, 32'h003100B3};
    vt[6]  = '{4'd2, 5'd5,  5'd6,  5'd7,  12'h000, 32'h007372B3};
    vt[7]  = '{4'd3, 5'd10, 5'd11, 5'd12, 12'h000, 32'h00C5E533};
    vt[8]  = '{4'd4, 5'd10, 5'd11, 5'd12, 12'h000, 32'h02C58533};
    vt[9]  = '{4'd7, 5'd0,  5'd2,  5'd31, 12'hFE4, 32'hFFF12223};
    vt[10] = '{4'd8, 5'd0,  5'd5,  5'd6,  12'h800, 32'h80628063};
    vt[11] = '{4'd8, 5'd0,  5'd0,  5'd0,  12'h400, 32'h000000E3};
    vt[12] = '{4'd8, 5'd0,  5'd0,  5'd0,  12'h3F0, 32'h7E000063};
    vt[13] = '{4'd5, 5'd31, 5'd31, 5'd0,  12'h800, 32'h800F8F93};

    // Reset state, observed while reset is still asserted.
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Table: one push, check head, pop.
    exp_addr = 32'd0;
    for (int i = 0; i < 14; i++) begin
      push(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_instr", i), instr, vt[i].exp);
      chk($sformatf("vec%0d_addr", i), addr, exp_addr);
      chk($sformatf("vec%0d_err", i), err, 1'b0);
      if (vt[i].op >= 4'd5)
        chk($sformatf("vec%0d_roundtrip", i), imm_of(vt[i].op, instr), vt[i].imm);
      pop_one($sformatf("vec%0d", i));
      exp_addr = exp_addr + 32'd4;
    end

    // Streaming with out_ready held: SW then BEQ back to back.
    do_clear();
    @(negedge clk);
    set_fields(4'd7, 5'd0, 5'd3, 5'd2, 12'h008);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 set_fields(4'd8, 5'd0, 5'd1, 5'd2, 12'h004);
    @(negedge clk);
    chk("stream_sw_instr", instr, 32'h0021A423);
    chk("stream_sw_addr", addr, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("stream_beq_valid", out_valid, 1'b1);
    chk("stream_beq_instr", instr, 32'h00208463);
    chk("stream_beq_addr", addr, 32'd4);
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("stream_drained", out_valid, 1'b0);

    // Full buffer: third push stalls, and a pop on a full buffer admits nothing.
    do_clear();
    push(4'd6, 5'd5, 5'd6, 5'd0, 12'hFFC);
    push(4'd1, 5'd3, 5'd1, 5'd2, 12'h000);
    @(negedge clk);
    chk("full_ready", in_ready, 1'b0);
    chk("full_head", instr, 32'hFFC32283);
    set_fields(4'd0, 5'd1, 5'd2, 5'd3, 12'h000);
    in_valid = 1'b1;
    @(negedge clk);
    chk("stall_head", instr, 32'hFFC32283);
    chk("stall_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_head", instr, 32'h402081B3);
    chk("release_addr", addr, 32'd4);
    chk("release_ready", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("third_head", instr, 32'h003100B3);
    chk("third_addr", addr, 32'd8);
    chk("third_valid", out_valid, 1'b1);
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("full_drained", out_valid, 1'b0);

    // Illegal ops, sticky error, clear with a push presented in the same cycle.
    do_clear();
    push(4'd12, 5'd1, 5'd2, 5'd3, 12'h055);
    @(negedge clk);
    chk("ill12_instr", instr, 32'h00000013);
    chk("ill12_err", err, 1'b1);
    chk("ill12_addr", addr, 32'd0);
    pop_one("ill12");
    push(4'd9, 5'd4, 5'd0, 5'd0, 12'h000);
    @(negedge clk);
    chk("ill9_instr", instr, 32'h00000013);
    chk("ill9_addr", addr, 32'd4);
    pop_one("ill9");
    push(4'd5, 5'd1, 5'd0, 5'd0, 12'h00A);
    @(negedge clk);
    chk("sticky_instr", instr, 32'h00A00093);
    chk("sticky_addr", addr, 32'd8);
    chk("sticky_err", err, 1'b1);
    @(negedge clk);
    clear = 1'b1;
    set_fields(4'd6, 5'd5, 5'd6, 5'd0, 12'hFFC);
    in_valid = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_valid", out_valid, 1'b0);
    chk("clr_err", err, 1'b0);
    chk("clr_ready", in_ready, 1'b1);
    chk("clr_addr", addr, 32'd0);
    push(4'd5, 5'd1, 5'd0, 5'd0, 12'h00A);
    @(negedge clk);
    chk("postclr_instr", instr, 32'h00A00093);
    chk("postclr_addr", addr, 32'd0);
    pop_one("postclr");

    // rd = x0 on a register-writing op.
    do_clear();
    push(4'd0, 5'd0, 5'd1, 5'd2, 12'h000);
    @(negedge clk);
`ifdef INSTR_ENC_X0_GUARD_EN
    chk("x0_instr", instr, 32'h00000013);
    chk("x0_err", err, 1'b1);
`else
    chk("x0_instr", instr, 32'h00208033);
    chk("x0_err", err, 1'b0);
`endif
    pop_one("x0");

    // Asynchronous reset with two entries queued and the error flag set.
    do_clear();
    push(4'd15, 5'd1, 5'd1, 5'd1, 12'h000);
    push(4'd5, 5'd1, 5'd0, 5'd0, 12'h00A);
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_err", err, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_err", err, 1'b0);
    chk("arst_addr", addr, 32'd0);
    chk("arst_instr", instr, 32'd0);
    chk("arst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
